// File: rtl/interrupts_nch.sv
// Vectored Z80 IM2 interrupt controller for NCH sources: per-channel enable, edge/level mode, fixed priority, nesting.
// Latency: int_n is registered one clk after req/ena/isr change; the vector follows the priority latched at M1 start.
// Backpressure: none; every command strobe and source strobe is taken in the clk it is presented.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   m1_n, iorq_n      Z80 M1 / IORQ, asynchronous to clk
//   int_n             registered Z80 INT (active low)
//   int_vector        IM2 vector of the latched priority source
//   din               command data: din[7] = set/clear value, din[NCH-1:0] = channel mask
//   ena_wr, req_wr    1-clk strobes writing the enable / request registers
//   eoi_wr            1-clk strobe: clear the highest-priority in-service bit
//   int_src           edge channels: 1-clk strobes; level channels: active-high levels
//   req_rd, isr_rd    request / in-service register readback
module interrupts_nch #(
  parameter int         NCH     = 6,
  parameter logic [6:0] LVLMASK = 7'b0000000,
  parameter logic [7:0] VBASE   = 8'h00
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m1_n,
  input  logic           iorq_n,
  output logic           int_n,
  output logic [7:0]     int_vector,
  input  logic [7:0]     din,
  input  logic           ena_wr,
  input  logic           req_wr,
  input  logic           eoi_wr,
  input  logic [NCH-1:0] int_src,
  output logic [NCH-1:0] req_rd,
  output logic [NCH-1:0] isr_rd
);

  logic           m1_s1, m1_s2;
  logic           ack_s1, ack_s2;
  logic           m1_beg, iack_end;
  logic [NCH-1:0] ena, req, isr, pri;
  logic [NCH-1:0] ena_next, req_next, isr_clr, pri_next;
  logic [NCH-1:0] hmask, cand;
  logic           run;
  logic [2:0]     idx;
  logic           unused_din;

  // Only din[NCH-1:0] and din[7] carry meaning; the rest is don't-care.
  assign unused_din = ^din;

  // M1 synchroniser on the rising edge; m1_beg marks M1 going low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_s1 <= 1'b1;
      m1_s2 <= 1'b1;
    end else begin
      m1_s1 <= m1_n;
      m1_s2 <= m1_s1;
    end
  end

  // Acknowledge cycle (M1 and IORQ both low) synchronised on the falling
  // edge, so its end is visible to the very next rising edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      ack_s1 <= iorq_n | m1_n;
      ack_s2 <= ack_s1;
    end
  end

  assign m1_beg   = m1_s2 & ~m1_s1;
  assign iack_end = ack_s1 & ~ack_s2;

  always_comb begin
    hmask    = '0;
    cand     = '0;
    pri_next = '0;
    isr_clr  = '0;
    ena_next = ena;
    req_next = req;
    idx      = 3'd7;
    run      = 1'b1;

    // A channel may request only while no channel of equal or higher
    // priority is in service.
    for (int i = 0; i < NCH; i++) begin
      run      = run & ~isr[i];
      hmask[i] = run;
    end
    cand = req & ena & hmask;

    // Descending scans: the last hit is the lowest index (highest priority).
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pri_next    = '0;
        pri_next[i] = 1'b1;
      end
      if (isr[i]) begin
        isr_clr    = '0;
        isr_clr[i] = eoi_wr;
      end
      if (pri[i]) idx = 3'(i);
    end

    for (int i = 0; i < NCH; i++) begin
      if (ena_wr && din[i]) ena_next[i] = din[7];

      if (LVLMASK[i]) begin
        req_next[i] = int_src[i];
      end else if (int_src[i]) begin
        // A fresh strobe beats both the acknowledge clear and a software clear.
        req_next[i] = 1'b1;
      end else if (iack_end && pri[i]) begin
        req_next[i] = 1'b0;
      end else if (req_wr && din[i]) begin
        req_next[i] = din[7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena   <= NCH'(1);
      req   <= '0;
      isr   <= '0;
      pri   <= '0;
      int_n <= 1'b1;
    end else begin
      ena   <= ena_next;
      req   <= req_next;
      // EOI clear is taken from the old isr; an acknowledge set wins on the same bit.
      isr   <= (isr & ~isr_clr) | (iack_end ? pri : '0);
      if (m1_beg) pri <= pri_next;
      int_n <= ~|cand;
    end
  end

  // pri = 0 (spurious acknowledge) yields idx 7.
  assign int_vector = VBASE | {4'b0000, idx, 1'b0};
  assign req_rd     = req;
  assign isr_rd     = isr;

endmodule

// File: tb/tb_interrupts_nch.sv
module tb_interrupts_nch;
  localparam int         NCH = 6;
  localparam logic [6:0] LVL = 7'b0000100;
  localparam logic [7:0] VB  = 8'h00;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           m1_n = 1'b1;
  logic           iorq_n = 1'b1;
  logic           ena_wr = 1'b0;
  logic           req_wr = 1'b0;
  logic           eoi_wr = 1'b0;
  logic [7:0]     din = 8'h00;
  logic [NCH-1:0] int_src = '0;
  logic [NCH-1:0] lvl_src = '0;
  logic           int_n;
  logic [7:0]     int_vector;
  logic [NCH-1:0] req_rd, isr_rd;

  int total = 0;
  int bad = 0;

  // Reference model: plain per-channel flags plus the index of the latched source.
  bit m_en[NCH];
  bit m_rq[NCH];
  bit m_is[NCH];
  int m_pri;

  interrupts_nch #(.NCH(NCH), .LVLMASK(LVL), .VBASE(VB)) dut (
    .clk(clk), .rst_n(rst_n), .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n),
    .int_vector(int_vector), .din(din), .ena_wr(ena_wr), .req_wr(req_wr),
    .eoi_wr(eoi_wr), .int_src(int_src), .req_rd(req_rd), .isr_rd(isr_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [NCH-1:0] mask);
    int_src = lvl_src | mask;
    tick(1);
    int_src = lvl_src;
  endtask

  task automatic wr_ena(input logic [7:0] d);
    din = d; ena_wr = 1'b1; tick(1); ena_wr = 1'b0;
  endtask

  task automatic wr_req(input logic [7:0] d);
    din = d; req_wr = 1'b1; tick(1); req_wr = 1'b0;
  endtask

  task automatic eoi();
    eoi_wr = 1'b1; tick(1); eoi_wr = 1'b0;
  endtask

  task automatic do_ack();
    m1_n = 1'b0; tick(4);
    iorq_n = 1'b0; tick(3);
    m1_n = 1'b1; iorq_n = 1'b1; tick(4);
  endtask

  // ---------------- model ----------------
  function automatic bit req_of(int i);
    return LVL[i] ? lvl_src[i] : m_rq[i];
  endfunction

  function automatic bit elig(int i);
    if (!(req_of(i) && m_en[i])) return 1'b0;
    for (int j = 0; j <= i; j++) if (m_is[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_int_n();
    for (int i = 0; i < NCH; i++) if (elig(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_vec();
    return (m_pri < 0) ? (VB | 8'h0E) : (VB | 8'(2 * m_pri));
  endfunction

  function automatic logic [7:0] pack_req();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < NCH; i++) v[i] = req_of(i);
    return v;
  endfunction

  function automatic logic [7:0] pack_isr();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < NCH; i++) v[i] = m_is[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = (i == 0); m_rq[i] = 1'b0; m_is[i] = 1'b0;
    end
    m_pri = -1;
  endtask

  task automatic m_ack();
    m_pri = -1;
    for (int i = NCH - 1; i >= 0; i--) if (elig(i)) m_pri = i;
    if (m_pri >= 0) begin
      m_is[m_pri] = 1'b1;
      if (!LVL[m_pri]) m_rq[m_pri] = 1'b0;
    end
  endtask

  task automatic m_eoi();
    for (int i = 0; i < NCH; i++) if (m_is[i]) begin m_is[i] = 1'b0; return; end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
  endtask

  initial begin
    logic [7:0] d;
    logic [NCH-1:0] mask;
    int op;

    // 1: reset state, single source and acknowledge
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_int_n", 8'(int_n), 8'h01);
    chk("rst_req", 8'(req_rd), 8'h00);
    chk("rst_isr", 8'(isr_rd), 8'h00);
    chk("rst_vec", int_vector, 8'h0E);
    strobe(6'b000001); tick(1);
    chk("t1_int_n", 8'(int_n), 8'h00);
    do_ack();
    chk("t1_vec", int_vector, 8'h00);
    chk("t1_req", 8'(req_rd), 8'h00);
    chk("t1_isr", 8'(isr_rd), 8'h01);
    chk("t1_int_n_ack", 8'(int_n), 8'h01);
    eoi(); tick(1);

    // 2: two simultaneous sources, lower index wins
    wr_ena(8'hBF);
    strobe(6'b001010); tick(1);
    do_ack();
    chk("t2_vec", int_vector, 8'h02);
    chk("t2_isr", 8'(isr_rd), 8'h02);
    chk("t2_req", 8'(req_rd), 8'h08);
    chk("t2_int_n", 8'(int_n), 8'h01);

    // 3: nesting and EOI order
    strobe(6'b000001); tick(1);
    chk("t3_int_n", 8'(int_n), 8'h00);
    do_ack();
    chk("t3_vec", int_vector, 8'h00);
    chk("t3_isr", 8'(isr_rd), 8'h03);
    eoi();
    chk("t3_eoi1", 8'(isr_rd), 8'h02);
    eoi();
    chk("t3_eoi2", 8'(isr_rd), 8'h00);
    tick(1);
    chk("t3_ch3_int_n", 8'(int_n), 8'h00);
    do_ack();
    chk("t3_ch3_vec", int_vector, 8'h06);
    eoi(); tick(1);

    // 4: level channel
    lvl_src = 6'b000100; int_src = lvl_src; tick(2);
    chk("t4_int_n", 8'(int_n), 8'h00);
    do_ack();
    chk("t4_vec", int_vector, 8'h04);
    chk("t4_req", 8'(req_rd), 8'h04);
    chk("t4_int_n_masked", 8'(int_n), 8'h01);
    eoi(); tick(1);
    chk("t4_int_n_reassert", 8'(int_n), 8'h00);
    lvl_src = '0; int_src = '0; tick(2);
    chk("t4_int_n_drop", 8'(int_n), 8'h01);

    // 5: strobe coinciding with acknowledge end
    strobe(6'b010000); tick(1);
    chk("t5_int_n", 8'(int_n), 8'h00);
    m1_n = 1'b0; tick(4);
    iorq_n = 1'b0; tick(3);
    m1_n = 1'b1; iorq_n = 1'b1; int_src = 6'b010000;
    tick(1);
    int_src = '0; tick(3);
    chk("t5_vec", int_vector, 8'h08);
    chk("t5_isr", 8'(isr_rd), 8'h10);
    chk("t5_req_kept", 8'(req_rd), 8'h10);
    wr_req(8'h10);
    chk("t5_req_clr", 8'(req_rd), 8'h00);
    eoi(); tick(1);

    // 6: spurious acknowledge, then reset mid-acknowledge
    do_ack();
    chk("t6_vec_spur", int_vector, 8'h0E);
    chk("t6_isr_spur", 8'(isr_rd), 8'h00);
    strobe(6'b000001); tick(1);
    m1_n = 1'b0; tick(4);
    chk("t6_vec_latched", int_vector, 8'h00);
    iorq_n = 1'b0; tick(1);
    rst_n = 1'b0; #2;
    chk("t6_rst_int_n", 8'(int_n), 8'h01);
    chk("t6_rst_req", 8'(req_rd), 8'h00);
    chk("t6_rst_vec", int_vector, 8'h0E);
    tick(1); rst_n = 1'b1; tick(3);
    m1_n = 1'b1; iorq_n = 1'b1; tick(4);
    chk("t6_post_vec", int_vector, 8'h0E);
    chk("t6_post_isr", 8'(isr_rd), 8'h00);
    strobe(6'b000010); tick(1);
    chk("t6_ena_reset", 8'(int_n), 8'h01);

    // Randomised operations against the model
    hard_reset();
    lvl_src = '0; int_src = '0;
    m_reset();
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          mask = NCH'($urandom) & ~LVL[NCH-1:0];
          strobe(mask);
          for (int i = 0; i < NCH; i++) if (mask[i]) m_rq[i] = 1'b1;
        end
        1: begin
          lvl_src = ($urandom_range(0, 1) == 1) ? LVL[NCH-1:0] : '0;
          int_src = lvl_src;
        end
        2: begin
          d = 8'($urandom);
          wr_ena(d);
          for (int i = 0; i < NCH; i++) if (d[i]) m_en[i] = d[7];
        end
        3: begin
          d = 8'($urandom);
          wr_req(d);
          for (int i = 0; i < NCH; i++) if (d[i] && !LVL[i]) m_rq[i] = d[7];
        end
        4: begin
          eoi();
          m_eoi();
        end
        default: begin
          m_ack();
          do_ack();
        end
      endcase
      tick(2);
      chk("rnd_int_n", 8'(int_n), 8'(exp_int_n()));
      chk("rnd_req", 8'(req_rd), pack_req());
      chk("rnd_isr", 8'(isr_rd), pack_isr());
      chk("rnd_vec", int_vector, exp_vec());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
